uart_rx_fifo: RTL and testbench

//   Receive buffer between the buart receiver and the CPU IO page. Drains each byte
//   out of the UART's single-byte holding register into a DEPTH-entry FIFO, so the CPU
//   can fall behind by many characters without losing input.

---
 rtl/uart_rx_fifo.sv | 122 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive buffer between the buart receiver and the CPU IO page: drains the UART holding
// register into a DEPTH-entry FIFO. Optional flow-control hold mode: UART_RX_FIFO_HOLD_EN.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_valid,
  input  logic [WIDTH-1:0]      uart_data,
  output logic                  uart_rd,
  input  logic                  cpu_rd,
  output logic [WIDTH-1:0]      cpu_data,
  output logic                  fifo_valid,
  output logic                  fifo_full,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  input  logic                  clr_ovf
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    SETTLE = 2'd2
  } ingest_state_t;

  ingest_state_t         state;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;

  logic capture;
  logic do_pop;
  logic accept;
  logic do_push;

  assign fifo_count = count;
  assign fifo_valid = (count != '0);
  assign fifo_full  = (count == FULL_COUNT);

  // A pop in the capture cycle frees the slot the incoming byte needs.
  assign capture = (state == IDLE) && uart_valid;
  assign do_pop  = cpu_rd && fifo_valid;
  assign accept  = !fifo_full || do_pop;
  assign do_push = capture && accept;

  assign cpu_data = fifo_valid ? mem[rptr] : '0;

  // NOTE: storage has no reset; validity is tracked by count, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= uart_data;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      uart_rd <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
    end else begin
      uart_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (uart_valid) begin
`ifdef UART_RX_FIFO_HOLD_EN
            // A refused byte is left in buart until a pop makes room.
            if (accept) begin
              state   <= ACK;
              uart_rd <= 1'b1;
            end
`else
            state   <= ACK;
            uart_rd <= 1'b1;
`endif
          end
        end
        ACK:     state <= SETTLE;
        SETTLE:  state <= IDLE;
        default: state <= IDLE;
      endcase

      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;

      case ({do_push, do_pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef UART_RX_FIFO_HOLD_EN
  assign overflow = 1'b0;
`else
  logic overflow_q;

  // Set has priority over clear so a drop in the clearing cycle is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (capture && !accept) begin
      overflow_q <= 1'b1;
    end else if (clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized run
// against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_valid;
  logic [7:0] uart_data;
  logic       uart_rd;
  logic       cpu_rd;
  logic [7:0] cpu_data;
  logic       fifo_valid;
  logic       fifo_full;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       clr_ovf;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  bit         ovf_m;

  uart_rx_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .uart_valid (uart_valid),
    .uart_data  (uart_data),
    .uart_rd    (uart_rd),
    .cpu_rd     (cpu_rd),
    .cpu_data   (cpu_data),
    .fifo_valid (fifo_valid),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: a byte arriving at a capture is kept if there is room, otherwise flagged.
  task automatic model_ingest(input logic [7:0] d);
    if (q.size() < 16) q.push_back(d);
    else ovf_m = 1'b1;
  endtask

  function automatic logic [7:0] model_head();
    return (q.size() != 0) ? q[0] : 8'h00;
  endfunction

  // Behaves like buart: holds valid until the ack pulse, then drops it and lets the FSM settle.
  task automatic send_byte(input logic [7:0] d, input int budget, output bit acked);
    uart_valid = 1'b1;
    uart_data  = d;
    acked      = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick;
      if (uart_rd === 1'b1) begin
        acked = 1'b1;
        break;
      end
    end
    if (acked) begin
      uart_valid = 1'b0;
      tick;
      tick;
    end
  endtask

  task automatic do_pop;
    cpu_rd = 1'b1;
    tick;
    cpu_rd = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic test_reset;
    rst = 1'b1; uart_valid = 1'b0; uart_data = 8'h00; cpu_rd = 1'b0; clr_ovf = 1'b0;
    tick;
    tick;
    vectors++;
    if ({fifo_valid, fifo_count, uart_rd, overflow, cpu_data} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset: valid=%b count=%0d rd=%b ovf=%b data=%h, want all zero",
               fifo_valid, fifo_count, uart_rd, overflow, cpu_data);
    end
    rst = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    tick;
  endtask

  task automatic test_single;
    uart_valid = 1'b1;
    uart_data  = 8'h41;
    vectors++;
    if (uart_rd !== 1'b0) begin
      miscompares++; $display("FAIL single_rd_before: got %b want 0", uart_rd);
    end
    tick;
    vectors++;
    if ({uart_rd, fifo_valid, fifo_count, cpu_data} !== {1'b1, 1'b1, 5'd1, 8'h41}) begin
      miscompares++;
      $display("FAIL single_capture: rd=%b valid=%b count=%0d data=%h, want 1 1 1 41",
               uart_rd, fifo_valid, fifo_count, cpu_data);
    end
    uart_valid = 1'b0;
    tick;
    vectors++;
    if (uart_rd !== 1'b0) begin
      miscompares++; $display("FAIL single_rd_pulse: got %b want 0", uart_rd);
    end
    tick;
    q.push_back(8'h41);
    do_pop;
    vectors++;
    if ({fifo_count, fifo_valid, cpu_data} !== {5'd0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL single_pop: count=%0d valid=%b data=%h, want 0 0 00",
               fifo_count, fifo_valid, cpu_data);
    end
  endtask

  task automatic test_wrap;
    bit acked;
    logic [7:0] d;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      send_byte(d, 8, acked);
      model_ingest(d);
    end
    vectors++;
    if (fifo_count !== 5'd10) begin
      miscompares++; $display("FAIL wrap_count10: got %0d want 10", fifo_count);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (cpu_data !== model_head()) begin
        miscompares++; $display("FAIL wrap_pop10[%0d]: got %h want %h", i, cpu_data, model_head());
      end
      do_pop;
    end
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), 8, acked);
      model_ingest(8'(i));
    end
    vectors++;
    if ({fifo_full, fifo_count} !== {1'b1, 5'd16}) begin
      miscompares++; $display("FAIL wrap_full: full=%b count=%0d want 1 16", fifo_full, fifo_count);
    end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (cpu_data !== 8'(i)) begin
        miscompares++; $display("FAIL wrap_pop16[%0d]: got %h want %h", i, cpu_data, 8'(i));
      end
      do_pop;
    end
    vectors++;
    if (fifo_count !== 5'd0) begin
      miscompares++; $display("FAIL wrap_empty: got %0d want 0", fifo_count);
    end
  endtask

  task automatic test_overflow;
    bit acked;
    bit saw_rd;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      send_byte(d, 8, acked);
      model_ingest(d);
    end
`ifndef UART_RX_FIFO_HOLD_EN
    send_byte(8'hAA, 8, acked);
    model_ingest(8'hAA);
    vectors++;
    if ({acked, overflow, fifo_count, cpu_data} !== {1'b1, ovf_m, 5'd16, model_head()}) begin
      miscompares++;
      $display("FAIL ovf_drop: ack=%b ovf=%b count=%0d head=%h, want 1 1 16 %h",
               acked, overflow, fifo_count, cpu_data, model_head());
    end
    clr_ovf = 1'b1;
    tick;
    clr_ovf = 1'b0;
    ovf_m = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++; $display("FAIL ovf_clear: got %b want 0", overflow);
    end
    // Drop and clear at the same edge: the drop must win.
    uart_valid = 1'b1;
    uart_data  = 8'hAB;
    clr_ovf    = 1'b1;
    tick;
    clr_ovf    = 1'b0;
    uart_valid = 1'b0;
    model_ingest(8'hAB);
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++; $display("FAIL ovf_set_wins: got %b want 1", overflow);
    end
    tick;
    tick;
    clr_ovf = 1'b1;
    tick;
    clr_ovf = 1'b0;
    ovf_m = 1'b0;
`else
    uart_valid = 1'b1;
    uart_data  = 8'hAA;
    saw_rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (uart_rd !== 1'b0) saw_rd = 1'b1;
    end
    vectors++;
    if ({saw_rd, overflow, fifo_count} !== {1'b0, 1'b0, 5'd16}) begin
      miscompares++;
      $display("FAIL hold_wait: rd_seen=%b ovf=%b count=%0d, want 0 0 16", saw_rd, overflow, fifo_count);
    end
    do_pop;
    q.push_back(8'hAA);
    vectors++;
    if (uart_rd !== 1'b1) begin
      miscompares++; $display("FAIL hold_ingest_ack: got %b want 1", uart_rd);
    end
    uart_valid = 1'b0;
    tick;
    tick;
    vectors++;
    if ({fifo_count, overflow, cpu_data} !== {5'd16, 1'b0, model_head()}) begin
      miscompares++;
      $display("FAIL hold_after: count=%0d ovf=%b head=%h, want 16 0 %h",
               fifo_count, overflow, cpu_data, model_head());
    end
`endif
  endtask

  task automatic test_simultaneous;
    uart_valid = 1'b1;
    uart_data  = 8'h55;
    cpu_rd     = 1'b1;
    tick;
    cpu_rd     = 1'b0;
    void'(q.pop_front());
    q.push_back(8'h55);
    vectors++;
    if ({uart_rd, fifo_count, overflow, cpu_data} !== {1'b1, 5'd16, 1'b0, model_head()}) begin
      miscompares++;
      $display("FAIL simul: rd=%b count=%0d ovf=%b head=%h, want 1 16 0 %h",
               uart_rd, fifo_count, overflow, cpu_data, model_head());
    end
    uart_valid = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_drain;
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (cpu_data !== model_head()) begin
        miscompares++; $display("FAIL drain[%0d]: got %h want %h", i, cpu_data, model_head());
      end
      do_pop;
    end
  endtask

  task automatic test_empty_and_reset;
    bit acked;
    do_pop;
    vectors++;
    if ({fifo_count, fifo_valid, cpu_data} !== {5'd0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL empty_rd: count=%0d valid=%b data=%h, want 0 0 00", fifo_count, fifo_valid, cpu_data);
    end
    send_byte(8'h77, 8, acked);
    model_ingest(8'h77);
    vectors++;
    if ({fifo_count, cpu_data} !== {5'd1, 8'h77}) begin
      miscompares++; $display("FAIL empty_then_push: count=%0d head=%h, want 1 77", fifo_count, cpu_data);
    end
    uart_valid = 1'b1;
    uart_data  = 8'h33;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    vectors++;
    if ({uart_rd, fifo_count} !== {1'b0, 5'd0}) begin
      miscompares++; $display("FAIL rst_in_ack: rd=%b count=%0d, want 0 0", uart_rd, fifo_count);
    end
    acked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (uart_rd === 1'b1) begin
        acked = 1'b1;
        break;
      end
    end
    uart_valid = 1'b0;
    model_ingest(8'h33);
    vectors++;
    if ({acked, fifo_count, cpu_data} !== {1'b1, 5'd1, 8'h33}) begin
      miscompares++;
      $display("FAIL rst_reingest: ack=%b count=%0d head=%h, want 1 1 33", acked, fifo_count, cpu_data);
    end
    tick;
    tick;
  endtask

  task automatic test_random;
    bit acked;
    logic [7:0] d;
    int r;
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
`ifdef UART_RX_FIFO_HOLD_EN
      if (r < 5 && q.size() == 16) r = 5;
`endif
      if (r < 5) begin
        d = 8'($urandom);
        send_byte(d, 8, acked);
        model_ingest(d);
        vectors++;
        if (!acked) begin
          miscompares++; $display("FAIL rand_ack[%0d]: no uart_rd within 8 cycles", n);
          uart_valid = 1'b0;
          tick;
          tick;
        end
      end else if (r < 9) begin
        do_pop;
      end else begin
        clr_ovf = 1'b1;
        tick;
        clr_ovf = 1'b0;
        ovf_m = 1'b0;
      end
      vectors++;
      if ({fifo_count, fifo_full, fifo_valid, overflow, cpu_data} !==
          {5'(q.size()), q.size() == 16, q.size() != 0, ovf_m, model_head()}) begin
        miscompares++;
        $display("FAIL rand_state[%0d]: count=%0d full=%b valid=%b ovf=%b head=%h, want %0d %b %b %b %h",
                 n, fifo_count, fifo_full, fifo_valid, overflow, cpu_data,
                 q.size(), q.size() == 16, q.size() != 0, ovf_m, model_head());
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_wrap;
    test_overflow;
    test_simultaneous;
    test_drain;
    test_empty_and_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
